bus_dev_port_fifo: RTL and testbench

//  Per-device port between one bus agent/device and the bus generator/arbiter (bs_gnrtr_n_rbtr).
//  TX path: buffers device packets and exposes them to the arbiter via pndng/D_pop/pop.
//  RX path: captures packets delivered via push/D_push and holds them until the device reads them.
//  One instance per driver index; the bench instantiates drvrs copies.

---
 rtl/bus_port_pkg.sv | 18 +
 rtl/sync_fifo_fwft.sv | 97 +++++++++
 rtl/bus_dev_port_fifo.sv | 135 +++++++++++++
 tb/tb_bus_dev_port_fifo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bus_port_pkg.sv
// Shared definitions for the per-device bus port.
// Holds the destination-ID width, the broadcast ID and a helper that
// extracts the destination ID from the top bits of a packet.
package bus_port_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  // Widest packet the helper accepts; narrower packets are zero-extended.
  localparam int MAX_PKT_W = 256;

  // Destination ID lives in the top ID_W bits of a pkt_w-bit packet.
  function automatic logic [ID_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                               input int pkt_w);
    return pkt[pkt_w-1 -: ID_W];
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   wr, wdata, full   write side; a write while full is dropped unless a read
//                     happens in the same cycle
//   rd, rdata, empty  read side; rdata always shows the entry at the read pointer
//   overflow          single-cycle pulse: a write was dropped this cycle
// The memory is not reset; only pointers and the occupancy count are.
module sync_fifo_fwft
  import bus_port_pkg::*;
#(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] wdata,
  output logic             full,
  input  logic             rd,
  output logic [width-1:0] rdata,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             rd_en_s;
  logic             wr_en_s;

  // Accept/drop decisions and next pointer/count values.
  always_comb begin
    rd_en_s  = 1'b0;
    wr_en_s  = 1'b0;
    overflow = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // A read on an empty FIFO is ignored.
    rd_en_s = rd && (count_q != CW'(0));
    // A simultaneous read frees the slot, so a write into a full FIFO still lands.
    wr_en_s = wr && ((count_q != CW'(depth)) || rd_en_s);
    if (wr && !wr_en_s) begin
      overflow = 1'b1;
    end else begin
      overflow = 1'b0;
    end

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; a write during reset must not land, contents are otherwise kept.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign full  = (count_q == CW'(depth));
  assign empty = (count_q == CW'(0));
  assign rdata = mem_q[rd_ptr_q];

endmodule

// File: rtl/bus_dev_port_fifo.sv
// Per-device port between a bus device and the bus generator/arbiter.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   tx_wr, tx_data, tx_full device side of the TX FIFO
//   pndng, D_pop, pop       arbiter side of the TX FIFO (FWFT head on D_pop)
//   push, D_push            arbiter delivers a packet into the RX FIFO
//   rx_valid, rx_data, rx_rd device side of the RX FIFO (FWFT head on rx_data)
//   tx_ovf_cnt, rx_drop_cnt saturating counts of dropped TX writes / RX pushes
//   misroute                sticky: a push carried a destination that is neither
//                           this port's id nor the broadcast ID
module bus_dev_port_fifo
  import bus_port_pkg::*;
#(
  parameter int              pckg_sz   = 16,
  parameter int              depth     = 8,
  parameter int              id        = 0,
  parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_rd,
  output logic [7:0]         tx_ovf_cnt,
  output logic [7:0]         rx_drop_cnt,
  output logic               misroute
);

  logic            tx_empty_s;
  logic            rx_empty_s;
  logic            rx_full_s;
  logic            tx_ovf_s;
  logic            rx_ovf_s;
  logic [ID_W-1:0] dest_s;
  logic            wrong_dest_s;

  logic [7:0] tx_ovf_cnt_q,  tx_ovf_cnt_d;
  logic [7:0] rx_drop_cnt_q, rx_drop_cnt_d;
  logic       misroute_q,    misroute_d;

  sync_fifo_fwft #(
    .width (pckg_sz),
    .depth (depth)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr       (tx_wr),
    .wdata    (tx_data),
    .full     (tx_full),
    .rd       (pop),
    .rdata    (D_pop),
    .empty    (tx_empty_s),
    .overflow (tx_ovf_s)
  );

  sync_fifo_fwft #(
    .width (pckg_sz),
    .depth (depth)
  ) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr       (push),
    .wdata    (D_push),
    .full     (rx_full_s),
    .rd       (rx_rd),
    .rdata    (rx_data),
    .empty    (rx_empty_s),
    .overflow (rx_ovf_s)
  );

  assign pndng    = !tx_empty_s;
  assign rx_valid = !rx_empty_s;

  // Destination check applies to every push, whether it is stored or dropped.
  always_comb begin
    dest_s       = dest_of(MAX_PKT_W'(D_push), pckg_sz);
    wrong_dest_s = 1'b0;
    if (push && (dest_s != ID_W'(id)) && (dest_s != broadcast)) begin
      wrong_dest_s = 1'b1;
    end else begin
      wrong_dest_s = 1'b0;
    end
  end

  // Saturating drop counters and sticky misroute flag next-state.
  always_comb begin
    tx_ovf_cnt_d  = tx_ovf_cnt_q;
    rx_drop_cnt_d = rx_drop_cnt_q;
    misroute_d    = misroute_q;

    if (tx_ovf_s && (tx_ovf_cnt_q != 8'hFF)) begin
      tx_ovf_cnt_d = tx_ovf_cnt_q + 8'd1;
    end else begin
      tx_ovf_cnt_d = tx_ovf_cnt_q;
    end

    if (rx_ovf_s && (rx_drop_cnt_q != 8'hFF)) begin
      rx_drop_cnt_d = rx_drop_cnt_q + 8'd1;
    end else begin
      rx_drop_cnt_d = rx_drop_cnt_q;
    end

    if (wrong_dest_s) begin
      misroute_d = 1'b1;
    end else begin
      misroute_d = misroute_q;
    end
  end

  // Status registers; reset wins over any event in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf_cnt_q  <= 8'd0;
      rx_drop_cnt_q <= 8'd0;
      misroute_q    <= 1'b0;
    end else begin
      tx_ovf_cnt_q  <= tx_ovf_cnt_d;
      rx_drop_cnt_q <= rx_drop_cnt_d;
      misroute_q    <= misroute_d;
    end
  end

  assign tx_ovf_cnt  = tx_ovf_cnt_q;
  assign rx_drop_cnt = rx_drop_cnt_q;
  assign misroute    = misroute_q;

endmodule

// File: tb/tb_bus_dev_port_fifo.sv
module tb_bus_dev_port_fifo;

  localparam int PW    = 16;
  localparam int DEPTH = 4;
  localparam int ID    = 2;

  logic          clk;
  logic          reset;
  logic          tx_wr;
  logic [PW-1:0] tx_data;
  logic          tx_full;
  logic          pndng;
  logic [PW-1:0] D_pop;
  logic          pop;
  logic          push;
  logic [PW-1:0] D_push;
  logic          rx_valid;
  logic [PW-1:0] rx_data;
  logic          rx_rd;
  logic [7:0]    tx_ovf_cnt;
  logic [7:0]    rx_drop_cnt;
  logic          misroute;

  int n_assert = 0;
  int n_fail   = 0;

  logic [PW-1:0] tx_q[$];
  logic [PW-1:0] rx_q[$];
  int            exp_tx_ovf;
  int            exp_rx_drop;
  logic          exp_misroute;

  bus_dev_port_fifo #(
    .pckg_sz (PW),
    .depth   (DEPTH),
    .id      (ID)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_wr       (tx_wr),
    .tx_data     (tx_data),
    .tx_full     (tx_full),
    .pndng       (pndng),
    .D_pop       (D_pop),
    .pop         (pop),
    .push        (push),
    .D_push      (D_push),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_rd       (rx_rd),
    .tx_ovf_cnt  (tx_ovf_cnt),
    .rx_drop_cnt (rx_drop_cnt),
    .misroute    (misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the scoreboard state.
  task automatic check_all();
    chk("pndng",    PW'(pndng),    PW'(tx_q.size() != 0));
    chk("tx_full",  PW'(tx_full),  PW'(tx_q.size() == DEPTH));
    chk("rx_valid", PW'(rx_valid), PW'(rx_q.size() != 0));
    chk("tx_ovf_cnt",  PW'(tx_ovf_cnt),  PW'(exp_tx_ovf));
    chk("rx_drop_cnt", PW'(rx_drop_cnt), PW'(exp_rx_drop));
    chk("misroute", PW'(misroute), PW'(exp_misroute));
    if (tx_q.size() != 0) chk("D_pop", D_pop, tx_q[0]);
    if (rx_q.size() != 0) chk("rx_data", rx_data, rx_q[0]);
  endtask

  // One clock cycle with the given inputs; the scoreboard follows the expected FIFO rules.
  task automatic step(input logic wr, input logic [PW-1:0] wd, input logic p,
                      input logic ps, input logic [PW-1:0] pd, input logic rr);
    bit tx_rd_e, tx_acc, rx_rd_e, rx_acc;
    logic [7:0] dst;
    tx_wr = wr; tx_data = wd; pop = p;
    push = ps; D_push = pd; rx_rd = rr;
    tx_rd_e = p && (tx_q.size() != 0);
    tx_acc  = wr && ((tx_q.size() < DEPTH) || tx_rd_e);
    rx_rd_e = rr && (rx_q.size() != 0);
    rx_acc  = ps && ((rx_q.size() < DEPTH) || rx_rd_e);
    dst = pd[PW-1 -: 8];
    @(posedge clk);
    #1;
    if (tx_rd_e) void'(tx_q.pop_front());
    if (tx_acc) tx_q.push_back(wd);
    if (wr && !tx_acc && exp_tx_ovf < 255) exp_tx_ovf++;
    if (rx_rd_e) void'(rx_q.pop_front());
    if (rx_acc) rx_q.push_back(pd);
    if (ps && !rx_acc && exp_rx_drop < 255) exp_rx_drop++;
    if (ps && dst != 8'(ID) && dst != 8'hFF) exp_misroute = 1'b1;
    tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
    check_all();
  endtask

  // Reset with a pop and a misrouted push asserted in the same cycle.
  task automatic do_reset();
    reset = 1'b1; pop = 1'b1; push = 1'b1; D_push = 16'h0507; rx_rd = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
    tx_q.delete(); rx_q.delete();
    exp_tx_ovf = 0; exp_rx_drop = 0; exp_misroute = 1'b0;
    check_all();
  endtask

  initial begin
    reset = 1'b1; tx_wr = 1'b0; tx_data = 16'h0000; pop = 1'b0;
    push = 1'b0; D_push = 16'h0000; rx_rd = 1'b0;
    exp_tx_ovf = 0; exp_rx_drop = 0; exp_misroute = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // 1. Two writes then two pops.
    step(1'b1, 16'h0155, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("t1_first_head", D_pop, 16'h0155);
    step(1'b1, 16'h03AA, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("t1_second_head", D_pop, 16'h03AA);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("t1_drained", PW'(pndng), 16'h0000);

    // Pop on empty is ignored; write+pop on empty leaves one entry.
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h0777, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("wr_pop_empty", PW'(pndng), 16'h0001);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);

    // 2. Five writes, no pop: fourth fills, fifth drops.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'h1000 + PW'(i), 1'b0, 1'b0, 16'h0000, 1'b0);
      if (i == 3) chk("t2_full_after_4", PW'(tx_full), 16'h0001);
    end
    chk("t2_ovf", PW'(tx_ovf_cnt), 16'h0001);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);

    // 3. Full FIFO, write and pop together.
    for (int i = 0; i < 4; i++) step(1'b1, 16'h2000 + PW'(i), 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h2AAA, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("t3_still_full", PW'(tx_full), 16'h0001);
    chk("t3_ovf_same", PW'(tx_ovf_cnt), 16'h0001);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("t3_last_head", D_pop, 16'h2AAA);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);

    // 4. RX ordering and misroute detection.
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h02C3, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFF11, 1'b0);
    chk("t4_rx_head", rx_data, 16'h02C3);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("t4_rx_second", rx_data, 16'hFF11);
    chk("t4_no_misroute", PW'(misroute), 16'h0000);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0107, 1'b0);
    chk("t4_misroute", PW'(misroute), 16'h0001);
    chk("t4_stored", rx_data, 16'h0107);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);

    // 5. RX drops and TX counter saturation.
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0230 + PW'(i), 1'b0);
    chk("t5_rx_drop", PW'(rx_drop_cnt), 16'h0002);
    for (int i = 0; i < 4 + 300; i++) step(1'b1, 16'h3000 + PW'(i), 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("t5_tx_sat", PW'(tx_ovf_cnt), 16'h00FF);

    // 6. Reset with three entries in each FIFO.
    step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    chk("t6_pre_pndng", PW'(pndng), 16'h0001);
    do_reset();
    chk("t6_pndng", PW'(pndng), 16'h0000);
    chk("t6_rx_valid", PW'(rx_valid), 16'h0000);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h0ABC, 1'b0, 1'b1, 16'h02DE, 1'b0);
    chk("t6_post_tx", D_pop, 16'h0ABC);
    chk("t6_post_rx", rx_data, 16'h02DE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
